// File: rtl/dotp_pkg.sv
// Shared types and constants for the dot_product_3x1 feeder: FSM state encoding,
// the FP32 word type and the quiet-NaN value returned when the unit never answers.
package dotp_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        WAIT_CALC,
        ACK,
        OUT
    } state_t;

    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/dot_product_3x1_feeder.sv
// Initiator for the dot_product_3x1 serial operand interface: streams A then B words,
// waits for the result, acknowledges it and returns it upstream. Optional watchdog: DOTP_FEEDER_TIMEOUT_EN.
module dot_product_3x1_feeder
    import dotp_pkg::*;
#(
    parameter int NUM_ELEM       = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    iClk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [32*NUM_ELEM-1:0]  req_vec_a,
    input  logic [32*NUM_ELEM-1:0]  req_vec_b,
    input  logic                    dp_ready,
    output logic                    dp_data_valid,
    output fp32_t                   dp_data,
    input  logic                    dp_data_done,
    input  logic                    dp_calc_done,
    input  fp32_t                   dp_result,
    output logic                    dp_read_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output fp32_t                   res_data,
    output logic                    busy
`ifdef DOTP_FEEDER_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    localparam int NUM_WORDS = 2 * NUM_ELEM;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int OPS_W     = 32 * NUM_WORDS;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [OPS_W-1:0]   ops;

`ifdef DOTP_FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_cnt;
`endif

    // req_ready drops the moment reset is asserted, not one edge later.
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge iClk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ops           <= '0;
            dp_data_valid <= 1'b0;
            dp_data       <= '0;
            dp_read_done  <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
`ifdef DOTP_FEEDER_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            dp_read_done <= 1'b0;
`ifdef DOTP_FEEDER_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ops           <= {req_vec_b, req_vec_a};
                        cnt           <= '0;
                        dp_data       <= req_vec_a[31:0];
                        dp_data_valid <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    // ops[31:0] always holds the word on dp_data; shift on each transfer.
                    if (dp_ready) begin
                        if (cnt == CNT_W'(NUM_WORDS - 1)) begin
                            dp_data_valid <= 1'b0;
                            dp_data       <= '0;
                            state         <= WAIT_DONE;
`ifdef DOTP_FEEDER_TIMEOUT_EN
                            tmo_cnt       <= '0;
`endif
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            ops     <= ops >> 32;
                            dp_data <= ops[63:32];
                        end
                    end
                end
                WAIT_DONE, WAIT_CALC: begin
                    // A result arriving on the watchdog's last cycle still wins.
                    if (dp_calc_done) begin
                        res_data     <= dp_result;
                        dp_read_done <= 1'b1;
                        state        <= ACK;
                    end
`ifdef DOTP_FEEDER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        res_data    <= FP32_QNAN;
                        res_valid   <= 1'b1;
                        state       <= OUT;
                    end
`endif
                    else begin
`ifdef DOTP_FEEDER_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                        if (state == WAIT_DONE && dp_data_done) begin
                            state <= WAIT_CALC;
                        end
                    end
                end
                ACK: begin
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_3x1_feeder.sv
// Self-checking bench for dot_product_3x1_feeder: transaction-level model plus a
// behavioural dot-product unit; covers timeout only when DOTP_FEEDER_TIMEOUT_EN is defined.
module tb_dot_product_3x1_feeder;
    import dotp_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic            iClk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [32*N-1:0] req_vec_a;
    logic [32*N-1:0] req_vec_b;
    logic            dp_ready;
    logic            dp_data_valid;
    logic [31:0]     dp_data;
    logic            dp_data_done;
    logic            dp_calc_done;
    logic [31:0]     dp_result;
    logic            dp_read_done;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_data;
    logic            busy;
`ifdef DOTP_FEEDER_TIMEOUT_EN
    logic            timeout_err;
`endif

    dot_product_3x1_feeder #(.NUM_ELEM(N), .TIMEOUT_CYCLES(TMO)) dut (
        .iClk          (iClk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vec_a     (req_vec_a),
        .req_vec_b     (req_vec_b),
        .dp_ready      (dp_ready),
        .dp_data_valid (dp_data_valid),
        .dp_data       (dp_data),
        .dp_data_done  (dp_data_done),
        .dp_calc_done  (dp_calc_done),
        .dp_result     (dp_result),
        .dp_read_done  (dp_read_done),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy)
`ifdef DOTP_FEEDER_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    initial forever #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Transaction model: words still owed to the unit, waiting for a result,
    // acknowledge pulse, result presented upstream.
    logic [31:0] m_words[$];
    bit          m_busy, m_wait, m_ack, m_out, m_tmo;
    int          m_wcnt;
    logic [31:0] m_res;

    function automatic void model_clear();
        m_words.delete();
        m_busy = 0; m_wait = 0; m_ack = 0; m_out = 0; m_tmo = 0;
        m_wcnt = 0; m_res = '0;
    endfunction

    // Observation logs used by the directed checks.
    logic [31:0] rx_log[$];
    int          rx_cyc[$];
    int          rd_pulses;
    int          cyc;

    task automatic clear_logs();
        rx_log.delete();
        rx_cyc.delete();
        rd_pulses = 0;
    endtask

    // Compare process: every falling edge, outputs against the model, then advance the model.
    initial begin
        bit was_busy, was_wait, was_ack, was_out;
        int nw;
        model_clear();
        cyc = 0;
        forever begin
            @(negedge iClk);
            cyc++;
            chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy && !rst});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("dp_data_valid", {31'b0, dp_data_valid}, {31'b0, m_words.size() > 0});
            if (m_words.size() > 0) chk("dp_data", dp_data, m_words[0]);
            chk("dp_read_done", {31'b0, dp_read_done}, {31'b0, m_ack});
            chk("res_valid", {31'b0, res_valid}, {31'b0, m_out});
            if (m_out) chk("res_data", res_data, m_res);
`ifdef DOTP_FEEDER_TIMEOUT_EN
            chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_tmo});
`endif
            if (dp_data_valid && dp_ready && !rst) begin
                rx_log.push_back(dp_data);
                rx_cyc.push_back(cyc);
            end
            if (dp_read_done) rd_pulses++;

            if (rst) begin
                model_clear();
            end else begin
                was_busy = m_busy; was_wait = m_wait; was_ack = m_ack; was_out = m_out;
                nw = m_words.size();
                m_tmo = 0;
                m_ack = 0;
                if (was_ack) m_out = 1;
                if (was_out && res_ready) begin
                    m_out  = 0;
                    m_busy = 0;
                end
                if (nw > 0 && dp_ready) begin
                    void'(m_words.pop_front());
                    if (m_words.size() == 0) begin
                        m_wait = 1;
                        m_wcnt = 0;
                    end
                end
                if (was_wait) begin
                    if (dp_calc_done) begin
                        m_res  = dp_result;
                        m_ack  = 1;
                        m_wait = 0;
                    end
`ifdef DOTP_FEEDER_TIMEOUT_EN
                    else begin
                        m_wcnt++;
                        if (m_wcnt == TMO) begin
                            m_tmo  = 1;
                            m_res  = FP32_QNAN;
                            m_out  = 1;
                            m_wait = 0;
                        end
                    end
`endif
                end
                if (!was_busy && req_valid) begin
                    m_busy = 1;
                    for (int i = 0; i < N; i++) m_words.push_back(req_vec_a[32*i +: 32]);
                    for (int i = 0; i < N; i++) m_words.push_back(req_vec_b[32*i +: 32]);
                end
            end
        end
    end

    // Behavioural dot-product unit. calc_mode: 0 result 3 cycles after data_done,
    // 1 result together with data_done, 2 never. ready_mode: 0 always, 1 pattern 1,0,0.
    int          calc_mode  = 0;
    int          ready_mode = 0;
    logic [31:0] um_result  = '0;

    initial begin
        bit xfer, rd;
        int um_rx, um_cd, um_cyc;
        um_rx = 0; um_cd = -1; um_cyc = 0;
        forever begin
            @(negedge iClk);
            xfer = dp_data_valid && dp_ready && !rst;
            rd   = dp_read_done;
            @(posedge iClk);
            #1;
            if (rst) begin
                um_rx = 0; um_cd = -1;
                dp_data_done = 0; dp_calc_done = 0;
            end else begin
                dp_data_done = 0;
                if (rd) dp_calc_done = 0;
                if (um_cd == 0) begin
                    dp_calc_done = 1;
                    dp_result    = um_result;
                    um_cd        = -1;
                end else if (um_cd > 0) begin
                    um_cd--;
                end
                if (xfer) begin
                    um_rx++;
                    if (um_rx == 2*N) begin
                        um_rx        = 0;
                        dp_data_done = 1;
                        if (calc_mode == 1) begin
                            dp_calc_done = 1;
                            dp_result    = um_result;
                        end else if (calc_mode == 0) begin
                            um_cd = 2;
                        end
                    end
                end
            end
            dp_ready = (ready_mode == 0) ? 1'b1 : (um_cyc % 3 == 0);
            um_cyc++;
        end
    end

    task automatic send_req(input logic [31:0] a0, a1, a2, b0, b1, b2);
        bit acc;
        acc       = 0;
        req_vec_a = {a2, a1, a0};
        req_vec_b = {b2, b1, b0};
        req_valid = 1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge iClk);
            acc = req_ready;
            @(posedge iClk);
            #1;
        end
        req_valid = 0;
        chk("req_accepted", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_res();
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge iClk);
            got = res_valid;
            if (!got) begin
                @(posedge iClk);
                #1;
            end
        end
        chk("res_valid_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic get_res(output logic [31:0] data);
        wait_res();
        data = res_data;
        @(posedge iClk);
        #1;
        res_ready = 1;
        @(negedge iClk);
        @(posedge iClk);
        #1;
        res_ready = 0;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    logic [31:0] exp_w[6];
    logic [31:0] d;

    initial begin
        bit seen;
        int k;
        rst = 1; req_valid = 0; req_vec_a = '0; req_vec_b = '0;
        dp_ready = 1; dp_data_done = 0; dp_calc_done = 0; dp_result = '0; res_ready = 0;
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_dp_data_valid", {31'b0, dp_data_valid}, 32'd0);
        chk("rst_dp_data", dp_data, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        rst = 0;
        #1;
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
        tick();

        // Basic transaction, unit always ready.
        clear_logs();
        calc_mode = 0; ready_mode = 0; um_result = 32'h4200_0000;
        exp_w = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                  32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
        send_req(exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4], exp_w[5]);
        get_res(d);
        chk("basic_res", d, 32'h4200_0000);
        chk("basic_nwords", rx_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < rx_log.size(); i++) chk("basic_word", rx_log[i], exp_w[i]);
        if (rx_cyc.size() == 6) chk("basic_consecutive", rx_cyc[5] - rx_cyc[0], 32'd5);
        chk("basic_read_done", rd_pulses, 32'd1);
        tick();

        // Backpressure from the unit.
        clear_logs();
        ready_mode = 1; um_result = 32'h4100_0000;
        exp_w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                  32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
        send_req(exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4], exp_w[5]);
        get_res(d);
        chk("bp_res", d, 32'h4100_0000);
        chk("bp_nwords", rx_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < rx_log.size(); i++) chk("bp_word", rx_log[i], exp_w[i]);
        ready_mode = 0;
        tick();

        // Result arrives together with data_done.
        clear_logs();
        calc_mode = 1; um_result = 32'hC100_0000;
        send_req(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6);
        get_res(d);
        chk("early_res", d, 32'hC100_0000);
        chk("early_read_done", rd_pulses, 32'd1);
        calc_mode = 0;
        tick();

        // Upstream stall with a pending request.
        um_result = 32'h3F00_0000;
        send_req(32'hA1, 32'hA2, 32'hA3, 32'hB1, 32'hB2, 32'hB3);
        wait_res();
        for (int i = 0; i < 20; i++) begin
            @(posedge iClk);
            #1;
            if (i == 5) begin
                um_result = 32'h4049_0FDB;
                req_vec_a = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
                req_vec_b = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001};
                req_valid = 1;
            end
            @(negedge iClk);
            chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
            chk("stall_res_data", res_data, 32'h3F00_0000);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_busy", {31'b0, busy}, 32'd1);
        end
        tick();
        res_ready = 1;
        @(negedge iClk);
        tick();
        res_ready = 0;
        @(negedge iClk);
        chk("hs_req_ready", {31'b0, req_ready}, 32'd1);
        chk("hs_no_word_yet", {31'b0, dp_data_valid}, 32'd0);
        tick();
        @(negedge iClk);
        chk("hs_accept_valid", {31'b0, dp_data_valid}, 32'd1);
        chk("hs_accept_a0", dp_data, 32'hAAAA_0001);
        tick();
        req_valid = 0;
        get_res(d);
        chk("stall_second_res", d, 32'h4049_0FDB);
        tick();

        // Reset after the third word has been transferred.
        clear_logs();
        um_result = 32'h1234_5678;
        req_vec_a = {32'hC3, 32'hC2, 32'hC1};
        req_vec_b = {32'hD3, 32'hD2, 32'hD1};
        req_valid = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge iClk);
            seen = (rx_log.size() >= 3);
            if (rx_log.size() >= 1) req_valid = 0;
        end
        req_valid = 0;
        chk("mid_three_words", {31'b0, seen}, 32'd1);
        @(posedge iClk);
        #2;
        rst = 1;
        model_clear();
        #1;
        chk("mid_rst_valid", {31'b0, dp_data_valid}, 32'd0);
        chk("mid_rst_data", dp_data, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_res_data", res_data, 32'd0);
        @(posedge iClk);
        #3;
        rst = 0;
        tick();
        clear_logs();
        send_req(32'hE1, 32'hE2, 32'hE3, 32'hF1, 32'hF2, 32'hF3);
        get_res(d);
        chk("restart_first_word", (rx_log.size() > 0) ? rx_log[0] : 32'hDEAD_DEAD, 32'hE1);
        chk("restart_nwords", rx_log.size(), 32'd6);
        chk("restart_res", d, 32'h1234_5678);
        tick();

`ifdef DOTP_FEEDER_TIMEOUT_EN
        // Unit never produces a result.
        calc_mode = 2;
        send_req(32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 32'hC);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge iClk);
            seen = !dp_data_valid;
        end
        k = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge iClk);
            k++;
            seen = timeout_err;
        end
        chk("tmo_seen", {31'b0, seen}, 32'd1);
        chk("tmo_cycles", k, 32'd16);
        chk("tmo_res_data", res_data, 32'h7FC0_0000);
        tick();
        get_res(d);
        chk("tmo_res", d, 32'h7FC0_0000);
        calc_mode = 0;
        tick();
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
